// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port between the map,
// Link and enemy drawers, with registered pixel output and a burst watchdog.
//
// state   | meaning
// IDLE    | no owner; pick next requester round-robin from ptr
// GRANT   | one requester owns the port for a burst
// RELEASE | one-cycle gap so the finished requester can drop req
module vga_write_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int MAX_BURST = 19200
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [2:0]       px_valid,
    input  logic [2:0]       px_last,
    input  logic [3*X_W-1:0] px_x,
    input  logic [3*Y_W-1:0] px_y,
    input  logic [3*C_W-1:0] px_c,
    output logic [2:0]       gnt,
    output logic [2:0]       px_ready,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [C_W-1:0]   vga_colour,
    output logic             vga_plot,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [14:0] CNT_LAST = 15'(MAX_BURST - 1);

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [14:0] cnt, cnt_nxt;
    logic [2:0]  gnt_nxt;
    logic [2:0]  acc_vec;
    logic        accept;
    logic        burst_end;
    logic [1:0]  g_idx;
    logic [1:0]  win;
    logic [1:0]  cand;
    logic        found;
    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y;
    logic [C_W-1:0] sel_c;

    assign px_ready = (state == GRANT) ? gnt : 3'b000;
    assign busy     = (state != IDLE);
    assign acc_vec  = px_valid & px_ready;
    assign accept   = |acc_vec;

    always_comb begin
        g_idx = 2'd0;
        if (gnt[1]) g_idx = 2'd1;
        if (gnt[2]) g_idx = 2'd2;
        sel_x = px_x[int'(g_idx)*X_W +: X_W];
        sel_y = px_y[int'(g_idx)*Y_W +: Y_W];
        sel_c = px_c[int'(g_idx)*C_W +: C_W];
    end

    // First requester found scanning ptr, ptr+1, ptr+2 (mod 3) wins.
    always_comb begin
        win   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(ptr) + k) % 3);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = 3'b000;
                if (found) begin
                    gnt_nxt   = 3'b001 << win;
                    cnt_nxt   = 15'd0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (accept)
                    cnt_nxt = cnt + 15'd1;
                burst_end = (accept && ((|(acc_vec & px_last)) || (cnt == CNT_LAST)))
                         || (!(|(req & gnt)) && !accept);
                if (burst_end) begin
                    ptr_nxt   = (g_idx == 2'd2) ? 2'd0 : g_idx + 2'd1;
                    gnt_nxt   = 3'b000;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                gnt_nxt   = 3'b000;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = 3'b000;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= 3'b000;
            ptr   <= 2'd0;
            cnt   <= 15'd0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Adapter has no backpressure, so every accepted pixel is plotted next cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= accept;
            if (accept) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_c;
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a behavioural ownership model.
module tb_vga_write_arbiter;

    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int C_W  = 3;
    localparam int MAXB = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       req = '0, px_valid = '0, px_last = '0;
    logic [3*X_W-1:0] px_x = '0;
    logic [3*Y_W-1:0] px_y = '0;
    logic [3*C_W-1:0] px_c = '0;
    logic [2:0]       gnt, px_ready;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [C_W-1:0]   vga_colour;
    logic             vga_plot, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the port, whether we are in the post-burst gap,
    // next round-robin start, pixels taken in this burst, and the plotted pixel.
    int             m_owner = -1;
    bit             m_gap   = 1'b0;
    int             m_ptr   = 0;
    int             m_cnt   = 0;
    bit             m_plot  = 1'b0;
    logic [X_W-1:0] m_x = '0;
    logic [Y_W-1:0] m_y = '0;
    logic [C_W-1:0] m_c = '0;

    vga_write_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_BURST(MAXB)) dut (
        .clock(clock), .reset(reset), .req(req), .px_valid(px_valid), .px_last(px_last),
        .px_x(px_x), .px_y(px_y), .px_c(px_c), .gnt(gnt), .px_ready(px_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge();
        int  g;
        bit  acc;
        bit  done;
        if (!reset) begin
            m_owner = -1; m_gap = 0; m_ptr = 0; m_cnt = 0;
            m_plot = 0; m_x = '0; m_y = '0; m_c = '0;
        end else begin
            m_plot = 0;
            if (m_owner >= 0) begin
                g    = m_owner;
                acc  = px_valid[g];
                done = 0;
                if (acc) begin
                    m_plot = 1;
                    m_x = px_x[g*X_W +: X_W];
                    m_y = px_y[g*Y_W +: Y_W];
                    m_c = px_c[g*C_W +: C_W];
                    if (px_last[g] || m_cnt == MAXB - 1) done = 1;
                    m_cnt++;
                end else if (!req[g]) begin
                    done = 1;
                end
                if (done) begin
                    m_ptr   = (g + 1) % 3;
                    m_owner = -1;
                    m_gap   = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (req != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 3]) m_owner = (m_ptr + k) % 3;
                end
                m_cnt = 0;
            end
        end
    endtask

    task automatic cyc();
        logic [2:0] eg;
        @(posedge clock);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        chk("gnt", gnt, eg);
        chk("px_ready", px_ready, eg);
        chk("busy", busy, (m_owner >= 0) || m_gap);
        chk("vga_plot", vga_plot, m_plot);
        chk("vga_x", vga_x, m_x);
        chk("vga_y", vga_y, m_y);
        chk("vga_colour", vga_colour, m_c);
    endtask

    function automatic int gnt_idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int order[$];
        int gap, held, plots;
        bit done_loop;

        // reset values and first-arbitration priority
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_gnt", gnt, 3'b000);
            chk("rst_plot", vga_plot, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        reset = 1'b1;
        cyc();
        chk("first_gnt", gnt, 3'b001);
        px_valid = 3'b001; px_last = 3'b001;
        cyc();
        req = 3'b000; px_valid = 3'b000; px_last = 3'b000;
        cyc(); cyc();

        // single 4-pixel burst from requester 1
        req = 3'b010;
        cyc();
        chk("sb_gnt", gnt, 3'b010);
        px_valid = 3'b010;
        px_y[Y_W +: Y_W] = 7'd5;
        px_c[C_W +: C_W] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            px_x[X_W +: X_W] = 8'(10 + i);
            px_last = (i == 3) ? 3'b010 : 3'b000;
            cyc();
            chk("sb_plot", vga_plot, 1'b1);
            chk("sb_x", vga_x, 10 + i);
            chk("sb_y", vga_y, 5);
            chk("sb_c", vga_colour, 3'b100);
        end
        chk("sb_gnt_drop", gnt, 3'b000);
        req = 3'b000; px_valid = 3'b000; px_last = 3'b000;
        cyc();
        chk("sb_plot_end", vga_plot, 1'b0);
        req = 3'b111;
        cyc();
        chk("sb_ptr", gnt, 3'b100);
        px_valid = 3'b100; px_last = 3'b100;
        cyc();

        // round-robin with 2-pixel bursts, req held at 111
        px_valid = 3'b111; px_last = 3'b000;
        gap = 0; held = 0; done_loop = 0;
        for (int i = 0; i < 40 && !done_loop; i++) begin
            px_last = (held >= 2) ? 3'b111 : 3'b000;
            cyc();
            if (gnt != 3'b000) begin
                if (held == 0) begin
                    order.push_back(gnt_idx(gnt));
                    if (order.size() > 1) chk("rr_gap", gap, 2);
                    if (order.size() == 4) done_loop = 1;
                end
                held++;
                gap = 0;
            end else begin
                held = 0;
                gap++;
            end
        end
        chk("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_0", order[0], 0);
            chk("rr_1", order[1], 1);
            chk("rr_2", order[2], 2);
            chk("rr_3", order[3], 0);
        end
        px_valid = 3'b001; px_last = 3'b001;
        cyc();
        req = 3'b000; px_valid = 3'b000; px_last = 3'b000;
        cyc(); cyc();

        // watchdog: requester 2 streams without last, requester 0 pending
        req = 3'b101; px_valid = 3'b100; px_last = 3'b000;
        plots = 0; done_loop = 0;
        for (int i = 0; i < 30 && !done_loop; i++) begin
            px_x[2*X_W +: X_W] = 8'($urandom);
            px_y[2*Y_W +: Y_W] = 7'($urandom);
            cyc();
            if (vga_plot) plots++;
            if (gnt == 3'b001) done_loop = 1;
        end
        chk("wd_plots", plots, MAXB);
        chk("wd_next", gnt, 3'b001);

        // abort by requester 0 while requester 1 presents pixels ungranted
        req = 3'b011; px_valid = 3'b011; px_last = 3'b000;
        px_x[0 +: X_W] = 8'h21; px_x[X_W +: X_W] = 8'h99;
        cyc();
        chk("ab_x", vga_x, 8'h21);
        req = 3'b010; px_valid = 3'b010;
        cyc();
        chk("ab_gnt", gnt, 3'b000);
        chk("ab_busy", busy, 1'b1);
        chk("ab_plot", vga_plot, 1'b0);
        req = 3'b111;
        cyc();
        chk("ab_idle_plot", vga_plot, 1'b0);
        chk("ab_iso", vga_x, 8'h21);
        cyc();
        chk("ab_ptr", gnt, 3'b010);
        px_last = 3'b010;
        cyc();
        req = 3'b000; px_valid = 3'b000; px_last = 3'b000;
        cyc(); cyc();

        // reset during requester 0's third accept
        req = 3'b001;
        cyc();
        px_valid = 3'b001; px_x[0 +: X_W] = 8'h44;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rm_plot", vga_plot, 1'b0);
        chk("rm_gnt", gnt, 3'b000);
        chk("rm_busy", busy, 1'b0);
        chk("rm_x", vga_x, 8'h00);
        reset = 1'b1; req = 3'b111; px_valid = 3'b000;
        cyc();
        chk("rm_ptr", gnt, 3'b001);
        req = 3'b000;
        cyc(); cyc(); cyc();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            for (int r = 0; r < 3; r++) begin
                req[r]      = ($urandom_range(0, 3) != 0);
                px_valid[r] = ($urandom_range(0, 9) < 7);
                px_last[r]  = ($urandom_range(0, 5) == 0);
            end
            px_x = 24'($urandom);
            px_y = 21'($urandom);
            px_c = 9'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
